fifo_drain_ctrl: RTL

- Consumer-side controller for the transaction-layer 10-bit FIFO. It drives the FIFO's `pop`, captures the registered `data_out`, and presents words downstream on a valid/ready interface.
- Draining starts when `almost_empty` deasserts, or on an explicit flush. A 2-entry skid buffer absorbs the 1-cycle FIFO read latency under backpressure.
- It sits between the FIFO and the next transaction-layer stage and is the read-side partner of the push-side producer.

---
 rtl/fifo_drain_pkg.sv | 14 +
 rtl/skid_buffer2.sv | 58 +++++
 rtl/fifo_drain_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared constants for the FIFO drain controller
package fifo_drain_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int CNT_W_DEF  = 16;
  localparam int SKID_DEPTH = 2;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

endpackage

// File: rtl/skid_buffer2.sv
// rtl/skid_buffer2.sv - two-entry in-order skid buffer, head entry always visible
module skid_buffer2
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enq,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] entry0;
  logic [DATA_W-1:0] entry1;
  logic              do_deq;

  assign do_deq    = deq && (count != 2'd0);
  assign head_data = entry0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (clear) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({enq, do_deq})
        2'b10: begin
          if (count == 2'd0) entry0 <= enq_data;
          else               entry1 <= enq_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous enqueue/dequeue: occupancy unchanged, queue shifts.
          if (count == 2'd1) begin
            entry0 <= enq_data;
          end else begin
            entry0 <= entry1;
            entry1 <= enq_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - read-side FIFO drain controller with valid/ready output
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              flush,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  output logic              fifo_pop,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  words_sent,
  output logic [2:0]        state,
  output logic              idle,
  output logic              error
);

  logic [2:0] next_state;
  logic       inflight;
  logic [1:0] skid_count;
  logic [2:0] occ;
  logic       fire;
  logic       err_cond;
  logic       skid_clear;
  logic       skid_enq;

  assign out_valid = (skid_count != 2'd0) && (state != ST_ERROR);
  assign fire      = out_valid && out_ready;
  assign occ       = {1'b0, skid_count} + {2'b00, inflight};

  // Pop only when the word returning next cycle is guaranteed a skid slot.
  assign fifo_pop  = (state == ST_ACTIVE) && !fifo_empty &&
                     (occ < (3'(SKID_DEPTH) + {2'b00, fire}));

  assign err_cond   = (state != ST_RESET) && fifo_empty && !fifo_almost_empty;
  assign skid_clear = (state == ST_ERROR) || (next_state == ST_ERROR);
  assign skid_enq   = inflight && !skid_clear;
  assign idle       = (state == ST_IDLE);
  assign error      = (state == ST_ERROR);

  always_comb begin
    next_state = state;
    if (err_cond) begin
      next_state = ST_ERROR;
    end else begin
      case (state)
        ST_RESET:  next_state = ST_INIT;
        ST_INIT:   next_state = init ? ST_INIT : ST_IDLE;
        ST_IDLE: begin
          if (init)
            next_state = ST_INIT;
          else if (!fifo_almost_empty || (flush && !fifo_empty))
            next_state = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (fifo_empty && !inflight && (skid_count == 2'd0))
            next_state = ST_IDLE;
        end
        ST_ERROR:  next_state = ST_ERROR;
        default:   next_state = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESET;
      inflight   <= 1'b0;
      words_sent <= '0;
    end else begin
      state    <= next_state;
      inflight <= fifo_pop;
      if (fire) words_sent <= words_sent + 1'b1;
    end
  end

  skid_buffer2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (skid_clear),
    .enq       (skid_enq),
    .enq_data  (fifo_data_out),
    .deq       (fire),
    .head_data (out_data),
    .count     (skid_count)
  );

endmodule
